dynamic_branch: RTL

DYNAMIC_BRANCH -- requirements
Module: dynamic_branch

---
 rtl/dynamic_branch.sv | 96 +++++++++
 1 files changed

// File: rtl/dynamic_branch.sv
`default_nettype none
// ============================================================================
// Module      : dynamic_branch
// Description : 2-bit saturating-counter branch predictor with Execute-stage
//               misprediction recovery and resolve/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module dynamic_branch #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  JumpE,
    input  logic                  BranchE,
    input  logic                  ZeroE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  PredTakenE,
    output logic                  PredTakenF,
    output logic [DATA_WIDTH-1:0] PCBPU,
    output logic                  PCBPUSrc,
    output logic                  flushBranch,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  MispredCount
);

    localparam int         c_ENTRIES   = 1 << INDEX_BITS;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [1:0] c_WEAK_NT   = 2'b01;

    logic [1:0]            r_pht [c_ENTRIES];
    logic [CNT_WIDTH-1:0]  r_branch_count;
    logic [CNT_WIDTH-1:0]  r_mispred_count;

    logic [INDEX_BITS-1:0] w_fidx;
    logic [INDEX_BITS-1:0] w_uidx;
    logic                  w_is_branch;
    logic                  w_pred_taken;
    logic                  w_mispred;
    logic [DATA_WIDTH-1:0] w_bimm;
    logic                  w_unused_rd;

    assign w_fidx       = PCF[INDEX_BITS+1:2];
    assign w_uidx       = PCE[INDEX_BITS+1:2];
    assign w_is_branch  = (RD[6:0] == c_OP_BRANCH) && !JumpE;
    assign w_pred_taken = w_is_branch && r_pht[w_fidx][1];
    assign w_mispred    = BranchE && (PredTakenE != ZeroE);
    assign w_bimm       = {{(DATA_WIDTH-12){RD[31]}}, RD[7], RD[30:25], RD[11:8], 1'b0};
    assign w_unused_rd  = ^RD;

    // Execute-stage recovery outranks any fetch-stage prediction.
    always_comb begin
        PredTakenF  = 1'b0;
        PCBPUSrc    = 1'b0;
        flushBranch = 1'b0;
        PCBPU       = '0;
        if (!rst) begin
            if (w_mispred) begin
                flushBranch = 1'b1;
                PCBPUSrc    = 1'b1;
                PCBPU       = ZeroE ? PCTargetE : (PCE + DATA_WIDTH'(4));
            end else if (w_pred_taken) begin
                PredTakenF = 1'b1;
                PCBPUSrc   = 1'b1;
                PCBPU      = PCF + w_bimm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_pht[i] <= c_WEAK_NT;
            end
            r_branch_count  <= '0;
            r_mispred_count <= '0;
        end else if (BranchE) begin
            if (ZeroE) begin
                if (r_pht[w_uidx] != 2'b11) r_pht[w_uidx] <= r_pht[w_uidx] + 2'd1;
            end else begin
                if (r_pht[w_uidx] != 2'b00) r_pht[w_uidx] <= r_pht[w_uidx] - 2'd1;
            end
            r_branch_count <= r_branch_count + CNT_WIDTH'(1);
            if (w_mispred) r_mispred_count <= r_mispred_count + CNT_WIDTH'(1);
        end
    end

    assign BranchCount  = r_branch_count;
    assign MispredCount = r_mispred_count;

endmodule
`default_nettype wire
